// File: rtl/cnt_serializer_pkg.sv
// Shared definitions for the count serializer: FSM state encodings and default divider.
package prs_pkg;

  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PAR   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/cnt_serializer_if.sv
// Request/count inputs and serial frame outputs of cnt_serializer, grouped as one bundle.
interface cnt_serializer_if #(
  parameter int CNT_WIDTH = 8
);

  logic [CNT_WIDTH-1:0] i_cnt;
  logic                 i_req;
  logic                 o_cnt_rst;
  logic                 o_cs_n;
  logic                 o_sclk;
  logic                 o_sdata;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_cnt, i_req,
    input  o_cnt_rst, o_cs_n, o_sclk, o_sdata, o_busy, o_done
  );

  modport slave (
    input  i_cnt, i_req,
    output o_cnt_rst, o_cs_n, o_sclk, o_sdata, o_busy, o_done
  );

endinterface

// File: rtl/cnt_serializer_sclk_gen.sv
// Bit-time generator: phase is low for CLK_DIV cycles then high for CLK_DIV cycles;
// bit_end marks the final cycle of each bit time. Counters hold at zero while disabled.
module sclk_gen
  import prs_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  output logic phase,
  output logic bit_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic             half_end_s;

  assign half_end_s = (div_q == DIV_W'(CLK_DIV - 1));

  // Half-period counter and phase toggle.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!enable) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (half_end_s) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign bit_end = enable & phase_q & half_end_s;

endmodule

// File: rtl/cnt_serializer.sv
// Captures an upstream count on request and shifts it out MSB first as a framed serial word.
// Define CNT_SERIALIZER_PARITY_EN to append one even-parity bit after the data bits.
module cnt_serializer
  import prs_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int CLR_ON_READ = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cnt_serializer_if.slave    bus
);

  localparam int BIT_W = (CNT_WIDTH > 1) ? $clog2(CNT_WIDTH) : 1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 o_cs_n_q, o_cs_n_d;
  logic                 o_sdata_q, o_sdata_d;
  logic                 o_busy_q, o_busy_d;
  logic                 o_done_q, o_done_d;
  logic                 o_cnt_rst_q, o_cnt_rst_d;
  logic                 gen_en_s;
  logic                 sclk_phase_s;
  logic                 bit_end_s;
`ifdef CNT_SERIALIZER_PARITY_EN
  logic                 par_q, par_d;

  assign gen_en_s = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`else
  assign gen_en_s = (state_q == ST_SHIFT);
`endif

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (gen_en_s),
    .phase   (sclk_phase_s),
    .bit_end (bit_end_s)
  );

  // Frame sequencing, capture and shifting.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef CNT_SERIALIZER_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shift_d   = bus.i_cnt;
        bit_cnt_d = '0;
`ifdef CNT_SERIALIZER_PARITY_EN
        par_d     = ^bus.i_cnt;
`endif
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_end_s) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == BIT_W'(CNT_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef CNT_SERIALIZER_PARITY_EN
            state_d   = ST_PAR;
`else
            state_d   = ST_FIN;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef CNT_SERIALIZER_PARITY_EN
      ST_PAR: begin
        if (bit_end_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_PAR;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    o_busy_d    = (state_d != ST_IDLE);
    o_done_d    = (state_d == ST_FIN);
    o_cnt_rst_d = (CLR_ON_READ == 1) && (state_d == ST_LOAD);
    case (state_d)
      ST_SHIFT: begin
        o_cs_n_d  = 1'b0;
        o_sdata_d = shift_d[CNT_WIDTH-1];
      end
`ifdef CNT_SERIALIZER_PARITY_EN
      ST_PAR: begin
        o_cs_n_d  = 1'b0;
        o_sdata_d = par_d;
      end
`endif
      default: begin
        o_cs_n_d  = 1'b1;
        o_sdata_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
`ifdef CNT_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
      o_cs_n_q    <= 1'b1;
      o_sdata_q   <= 1'b0;
      o_busy_q    <= 1'b0;
      o_done_q    <= 1'b0;
      o_cnt_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef CNT_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
      o_cs_n_q    <= o_cs_n_d;
      o_sdata_q   <= o_sdata_d;
      o_busy_q    <= o_busy_d;
      o_done_q    <= o_done_d;
      o_cnt_rst_q <= o_cnt_rst_d;
    end
  end

  assign bus.o_cs_n    = o_cs_n_q;
  assign bus.o_sclk    = sclk_phase_s;
  assign bus.o_sdata   = o_sdata_q;
  assign bus.o_busy    = o_busy_q;
  assign bus.o_done    = o_done_q;
  assign bus.o_cnt_rst = o_cnt_rst_q;

endmodule

// File: tb/tb_cnt_serializer.sv
// Randomized self-checking bench for cnt_serializer (CNT_WIDTH=8, CLK_DIV=2, CLR_ON_READ=1).
module tb_cnt_serializer;

  localparam int W       = 8;
  localparam int DIV     = 2;
  localparam int BIT_CYC = 2 * DIV;
`ifdef CNT_SERIALIZER_PARITY_EN
  localparam int NBITS   = W + 1;
`else
  localparam int NBITS   = W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cnt_serializer_if #(.CNT_WIDTH(W)) bus ();

  cnt_serializer #(
    .CNT_WIDTH   (W),
    .CLK_DIV     (DIV),
    .CLR_ON_READ (1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations gathered by the monitor; only the monitor writes them.
  int   ncyc   = 0;
  int   cs_low = 0;
  int   viol   = 0;
  bit   bit_q[$];
  int   rst_cyc_q[$];
  int   done_cyc_q[$];
  logic prev_sclk  = 1'b0;
  logic prev_sdata = 1'b0;
  logic prev_cs_n  = 1'b1;

  // Baselines marking where the current observation window starts.
  int b_bits, b_cs, b_rst, b_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sample bits on SCLK rising edges and track frame-level protocol rules.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!bus.o_cs_n) cs_low <= cs_low + 1;
    if (bus.o_sclk && !prev_sclk && !bus.o_cs_n) bit_q.push_back(bus.o_sdata);
    if (bus.o_cnt_rst) rst_cyc_q.push_back(ncyc);
    if (bus.o_done) done_cyc_q.push_back(ncyc);
    if (bus.o_cs_n && bus.o_sdata) viol <= viol + 1;
    if (!bus.o_cs_n && (bus.o_sdata != prev_sdata) &&
        !(!bus.o_sclk && (prev_sclk || prev_cs_n))) viol <= viol + 1;
    if ((!bus.o_cs_n || bus.o_done || bus.o_cnt_rst) && !bus.o_busy) viol <= viol + 1;
    prev_sclk  <= bus.o_sclk;
    prev_sdata <= bus.o_sdata;
    prev_cs_n  <= bus.o_cs_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    b_bits = bit_q.size();
    b_cs   = cs_low;
    b_rst  = rst_cyc_q.size();
    b_done = done_cyc_q.size();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while ((done_cyc_q.size() - b_done) < n && k < budget) begin
      tick();
      k++;
    end
    check("frame_wait", ((done_cyc_q.size() - b_done) >= n), 1'b1);
  endtask

  // Reference: each frame is the captured value MSB first, plus even parity when enabled.
  task automatic check_frames(input int n, input logic [W-1:0] v, input bit b2b);
    bit          exp_q[$];
    logic [63:0] exp_v = '0;
    logic [63:0] got_v = '0;
    int          nr, nd;
    for (int f = 0; f < n; f++) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(v[i]);
      if (NBITS > W) exp_q.push_back(bit'($countones(v) % 2));
    end
    check("nbits", bit_q.size() - b_bits, n * NBITS);
    for (int i = 0; i < exp_q.size(); i++) begin
      exp_v = {exp_v[62:0], exp_q[i]};
      if (b_bits + i < bit_q.size()) got_v = {got_v[62:0], bit_q[b_bits + i]};
      else got_v = {got_v[62:0], 1'b0};
    end
    check("bits", got_v, exp_v);
    check("cs_low_cycles", cs_low - b_cs, n * NBITS * BIT_CYC);
    nr = rst_cyc_q.size() - b_rst;
    nd = done_cyc_q.size() - b_done;
    check("cnt_rst_pulses", nr, n);
    check("done_pulses", nd, n);
    for (int i = 0; i < nr && i < nd; i++) begin
      check("frame_len", done_cyc_q[b_done + i] - rst_cyc_q[b_rst + i], NBITS * BIT_CYC + 1);
      if (b2b && i > 0)
        check("b2b_gap", rst_cyc_q[b_rst + i] - done_cyc_q[b_done + i - 1], 2);
    end
  endtask

  task automatic do_frame(input logic [W-1:0] v);
    clear_obs();
    bus.i_cnt = v;
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
    wait_frames(1, 200);
    repeat (3) tick();
    check_frames(1, v, 1'b0);
  endtask

  initial begin
    logic [W-1:0] tbl[4];
    logic [W-1:0] v;
    int           k;
    tbl = '{8'hA5, 8'h07, 8'h00, 8'hFF};
    bus.i_cnt = '0;
    bus.i_req = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    check("reset_outs", {bus.o_cs_n, bus.o_sclk, bus.o_sdata, bus.o_busy, bus.o_done, bus.o_cnt_rst},
          6'b100000);
    rst_n = 1'b1;
    repeat (2) tick();

    foreach (tbl[i]) do_frame(tbl[i]);

    repeat (8) begin
      v = W'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      do_frame(v);
    end

    // Late i_cnt change and a stray request inside the frame.
    clear_obs();
    bus.i_cnt = 8'hA5;
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
    repeat (10) tick();
    bus.i_cnt = 8'h00;
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
    wait_frames(1, 200);
    repeat (20) tick();
    check_frames(1, 8'hA5, 1'b0);

    // Request held across three frames.
    clear_obs();
    v = W'($urandom);
    bus.i_cnt = v;
    bus.i_req = 1'b1;
    wait_frames(3, 400);
    bus.i_req = 1'b0;
    repeat (5) tick();
    check_frames(3, v, 1'b1);

    // One-cycle reset in the middle of a frame.
    clear_obs();
    bus.i_cnt = 8'hA5;
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
    k = 0;
    while ((bit_q.size() - b_bits) < 4 && k < 200) begin
      tick();
      k++;
    end
    check("reach_bit4", ((bit_q.size() - b_bits) >= 4), 1'b1);
    rst_n = 1'b0;
    tick();
    check("abort_outs", {bus.o_cs_n, bus.o_sclk, bus.o_sdata, bus.o_busy, bus.o_done}, 5'b10000);
    rst_n = 1'b1;
    repeat (5) tick();
    check("abort_no_done", done_cyc_q.size() - b_done, 0);
    do_frame(8'hA5);

    check("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
